// File: rtl/vp_pkg.sv
// Shared types and helpers for the value-predictor validator.
// Holds the queued prediction entry and a saturating adder.
package vp_pkg;

    localparam int VP_WORD_WIDTH = 32;

    typedef struct packed {
        logic [VP_WORD_WIDTH-1:0] pc;
        logic [VP_WORD_WIDTH-1:0] result;
        logic                     conf;
    } pred_entry_t;

    // Adds inc to cur, clamping at lim (the counter's all-ones value).
    function automatic logic [63:0] sat_add(
        input logic [63:0] cur,
        input logic [1:0]  inc,
        input logic [63:0] lim
    );
        logic [64:0] sum;
        sum = {1'b0, cur} + {63'd0, inc};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/vp_pred_queue.sv
// In-order circular buffer of predictions.
// Up to two writes and two reads per cycle.
module vp_pred_queue
    import vp_pkg::*;
#(
    parameter int  P_DEPTH = 64,
    localparam int AW      = $clog2(P_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        enq_cnt_i,
    input  pred_entry_t [1:0] enq_entry_i,
    input  logic [1:0]        deq_cnt_i,
    input  logic              flush_i,
    output pred_entry_t [1:0] head_o,
    output logic [AW:0]       count_o
);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [AW:0] wr1, rd1;

    pred_entry_t mem_q [P_DEPTH];

    assign wr1 = wr_q + (AW+1)'(1);
    assign rd1 = rd_q + (AW+1)'(1);

    always_comb begin
        wr_d = wr_q + (AW+1)'(enq_cnt_i);
        rd_d = rd_q + (AW+1)'(deq_cnt_i);
        if (flush_i) begin
            wr_d = wr_q;
            rd_d = wr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset; occupancy is carried by the pointers.
    always_ff @(posedge clk_i) begin
        if (!flush_i && enq_cnt_i != 2'd0) begin
            mem_q[wr_q[AW-1:0]] <= enq_entry_i[0];
        end
        if (!flush_i && enq_cnt_i == 2'd2) begin
            mem_q[wr1[AW-1:0]] <= enq_entry_i[1];
        end
    end

    assign head_o[0] = mem_q[rd_q[AW-1:0]];
    assign head_o[1] = mem_q[rd1[AW-1:0]];
    assign count_o   = wr_q - rd_q;

endmodule

// File: rtl/vp_validator.sv
// Consumer end of the value-predictor protocol: queues predictions,
// matches them against execution results and drives feedback.
module vp_validator
    import vp_pkg::*;
#(
    parameter int  P_NUM_PRED    = 2,
    parameter int  P_QUEUE_DEPTH = 64,
    parameter int  P_STAT_WIDTH  = 32,
    localparam int CW            = $clog2(P_QUEUE_DEPTH) + 1,
    localparam int W             = VP_WORD_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [P_NUM_PRED-1:0][W-1:0]  pred_pc_i,
    input  logic [P_NUM_PRED-1:0][W-1:0]  pred_result_i,
    input  logic [P_NUM_PRED-1:0]         pred_conf_i,
    input  logic [P_NUM_PRED-1:0]         pred_valid_i,
    input  logic [P_NUM_PRED-1:0][W-1:0]  exe_pc_i,
    input  logic [P_NUM_PRED-1:0][W-1:0]  exe_actual_i,
    input  logic [P_NUM_PRED-1:0]         exe_valid_i,
    input  logic                          flush_i,
    output logic [P_NUM_PRED-1:0][W-1:0]  fb_pc_o,
    output logic [P_NUM_PRED-1:0][W-1:0]  fb_actual_o,
    output logic [P_NUM_PRED-1:0]         fb_mispredict_o,
    output logic [P_NUM_PRED-1:0]         fb_conf_o,
    output logic [P_NUM_PRED-1:0]         fb_valid_o,
    output logic [CW-1:0]                 q_count_o,
    output logic [P_STAT_WIDTH-1:0]       stat_correct_o,
    output logic [P_STAT_WIDTH-1:0]       stat_mispred_o,
    output logic [P_STAT_WIDTH-1:0]       stat_drop_o,
    output logic                          err_pc_mismatch_o
);

    logic [1:0]          pv, ev;
    pred_entry_t [1:0]   pe, ce, he, me;
    logic [1:0][W-1:0]   epc, eact;
    logic [1:0]          take, hit, mis, ok, bad;
    logic [1:0]          deq_cnt, enq_cnt, n_valid, drop_cnt;
    logic [1:0]          c_inc, m_inc;
    logic [CW-1:0]       count, free;
    logic                pc_err;

    logic [1:0][W-1:0]   fb_pc_q, fb_act_q;
    logic [1:0]          fb_mis_q, fb_conf_q, fb_valid_q;
    logic [P_STAT_WIDTH-1:0] st_c_q, st_c_d;
    logic [P_STAT_WIDTH-1:0] st_m_q, st_m_d;
    logic [P_STAT_WIDTH-1:0] st_d_q, st_d_d;
    logic                err_q;

    // Pad the lane vectors to two lanes; lane 1 folds away when absent.
    always_comb begin
        pv   = '0;
        ev   = '0;
        pe   = '0;
        epc  = '0;
        eact = '0;
        for (int p = 0; p < P_NUM_PRED; p++) begin
            pv[p]        = pred_valid_i[p];
            ev[p]        = exe_valid_i[p];
            pe[p].pc     = pred_pc_i[p];
            pe[p].result = pred_result_i[p];
            pe[p].conf   = pred_conf_i[p];
            epc[p]       = exe_pc_i[p];
            eact[p]      = exe_actual_i[p];
        end
    end

    always_comb begin
        take    = '0;
        hit     = '0;
        mis     = '0;
        me      = '0;
        deq_cnt = '0;
        for (int p = 0; p < 2; p++) begin
            if (ev[p] && !flush_i && CW'(deq_cnt) < count) begin
                take[p] = 1'b1;
                me[p]   = he[deq_cnt[0]];
                deq_cnt = deq_cnt + 2'd1;
            end
            hit[p] = take[p] && (epc[p] == me[p].pc);
            mis[p] = me[p].result != eact[p];
        end
        pc_err = |(take & ~hit);
    end

    // Free space is measured after this cycle's pops.
    always_comb begin
        ce = pe;
        if (!pv[0]) begin
            ce[0] = pe[1];
        end
        n_valid = {1'b0, pv[0]} + {1'b0, pv[1]};
        free    = CW'(P_QUEUE_DEPTH) - (count - CW'(deq_cnt));
        if (flush_i) begin
            enq_cnt = 2'd0;
        end else if (CW'(n_valid) <= free) begin
            enq_cnt = n_valid;
        end else begin
            enq_cnt = free[1:0];
        end
        drop_cnt = n_valid - enq_cnt;
    end

    always_comb begin
        ok    = hit & {me[1].conf, me[0].conf} & ~mis;
        bad   = hit & {me[1].conf, me[0].conf} & mis;
        c_inc = {1'b0, ok[0]} + {1'b0, ok[1]};
        m_inc = {1'b0, bad[0]} + {1'b0, bad[1]};
        st_c_d = P_STAT_WIDTH'(sat_add(64'(st_c_q), c_inc,
                                       64'({P_STAT_WIDTH{1'b1}})));
        st_m_d = P_STAT_WIDTH'(sat_add(64'(st_m_q), m_inc,
                                       64'({P_STAT_WIDTH{1'b1}})));
        st_d_d = P_STAT_WIDTH'(sat_add(64'(st_d_q), drop_cnt,
                                       64'({P_STAT_WIDTH{1'b1}})));
    end

    vp_pred_queue #(
        .P_DEPTH (P_QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enq_cnt_i   (enq_cnt),
        .enq_entry_i (ce),
        .deq_cnt_i   (deq_cnt),
        .flush_i     (flush_i),
        .head_o      (he),
        .count_o     (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fb_pc_q    <= '0;
            fb_act_q   <= '0;
            fb_mis_q   <= '0;
            fb_conf_q  <= '0;
            fb_valid_q <= '0;
            st_c_q     <= '0;
            st_m_q     <= '0;
            st_d_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            fb_valid_q <= hit;
            for (int p = 0; p < 2; p++) begin
                if (hit[p]) begin
                    fb_pc_q[p]   <= me[p].pc;
                    fb_act_q[p]  <= eact[p];
                    fb_mis_q[p]  <= mis[p];
                    fb_conf_q[p] <= me[p].conf;
                end
            end
            st_c_q <= st_c_d;
            st_m_q <= st_m_d;
            st_d_q <= st_d_d;
            err_q  <= err_q | pc_err;
        end
    end

    assign fb_pc_o           = fb_pc_q[P_NUM_PRED-1:0];
    assign fb_actual_o       = fb_act_q[P_NUM_PRED-1:0];
    assign fb_mispredict_o   = fb_mis_q[P_NUM_PRED-1:0];
    assign fb_conf_o         = fb_conf_q[P_NUM_PRED-1:0];
    assign fb_valid_o        = fb_valid_q[P_NUM_PRED-1:0];
    assign q_count_o         = count;
    assign stat_correct_o    = st_c_q;
    assign stat_mispred_o    = st_m_q;
    assign stat_drop_o       = st_d_q;
    assign err_pc_mismatch_o = err_q;

endmodule

// File: tb/tb_vp_validator.sv
// Directed bench for vp_validator with a small queue model
// for the long streaming section.
module tb_vp_validator;
    import vp_pkg::*;

    localparam int NP = 2;
    localparam int D  = 64;
    localparam int SW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NP-1:0][31:0] pred_pc, pred_res, exe_pc, exe_act;
    logic [NP-1:0]       pred_conf, pred_v, exe_v;
    logic                flush;
    logic [NP-1:0][31:0] fb_pc, fb_act;
    logic [NP-1:0]       fb_mis, fb_conf, fb_v;
    logic [6:0]          qcnt;
    logic [SW-1:0]       s_c, s_m, s_d;
    logic                err;

    int total = 0;
    int bad = 0;

    pred_entry_t mq[$];
    pred_entry_t exp_e[2];
    pred_entry_t ne;
    logic [31:0] act_e[2];
    logic [1:0]  ev_r, pv_r, exv;
    int          idx;
    int          mc, mm, md;
    logic [31:0] pcb;

    always #5 clk = ~clk;

    vp_validator #(
        .P_NUM_PRED    (NP),
        .P_QUEUE_DEPTH (D),
        .P_STAT_WIDTH  (SW)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .pred_pc_i         (pred_pc),
        .pred_result_i     (pred_res),
        .pred_conf_i       (pred_conf),
        .pred_valid_i      (pred_v),
        .exe_pc_i          (exe_pc),
        .exe_actual_i      (exe_act),
        .exe_valid_i       (exe_v),
        .flush_i           (flush),
        .fb_pc_o           (fb_pc),
        .fb_actual_o       (fb_act),
        .fb_mispredict_o   (fb_mis),
        .fb_conf_o         (fb_conf),
        .fb_valid_o        (fb_v),
        .q_count_o         (qcnt),
        .stat_correct_o    (s_c),
        .stat_mispred_o    (s_m),
        .stat_drop_o       (s_d),
        .err_pc_mismatch_o (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_v = '0;
        exe_v  = '0;
        flush  = 1'b0;
    endtask

    task automatic set_pred(input int l, input logic [31:0] pc,
                            input logic [31:0] r, input logic c);
        pred_pc[l]   = pc;
        pred_res[l]  = r;
        pred_conf[l] = c;
        pred_v[l]    = 1'b1;
    endtask

    task automatic set_exe(input int l, input logic [31:0] pc,
                           input logic [31:0] a);
        exe_pc[l]  = pc;
        exe_act[l] = a;
        exe_v[l]   = 1'b1;
    endtask

    initial begin
        pred_pc = '0; pred_res = '0; pred_conf = '0;
        exe_pc = '0; exe_act = '0;
        idle();
        step();
        step();
        chk("rst_qcnt", 64'(qcnt), 0);
        chk("rst_fbv", 64'(fb_v), 0);
        chk("rst_sc", 64'(s_c), 0);
        chk("rst_sd", 64'(s_d), 0);
        chk("rst_err", 64'(err), 0);
        rst_n = 1'b1;

        // reset in the middle of traffic
        set_pred(0, 32'h200, 5, 1); set_pred(1, 32'h204, 6, 0);
        step(); idle();
        set_pred(0, 32'h208, 0, 0); set_pred(1, 32'h20c, 0, 0);
        step(); idle();
        set_pred(0, 32'h210, 0, 0); set_pred(1, 32'h214, 0, 0);
        step(); idle();
        set_exe(0, 32'h200, 5);
        step(); idle();
        chk("t1_pre_fbv", 64'(fb_v), 1);
        chk("t1_pre_sc", 64'(s_c), 1);
        chk("t1_pre_qcnt", 64'(qcnt), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_qcnt", 64'(qcnt), 0);
        chk("t1_rst_fbv", 64'(fb_v), 0);
        chk("t1_rst_sc", 64'(s_c), 0);
        step();
        rst_n = 1'b1;
        set_pred(0, 32'h100, 7, 0);
        step(); idle();
        chk("t1_qcnt1", 64'(qcnt), 1);
        set_exe(0, 32'h100, 7);
        step(); idle();
        chk("t1_fbv", 64'(fb_v), 1);
        chk("t1_mis", 64'(fb_mis), 0);
        chk("t1_pc", 64'(fb_pc[0]), 32'h100);
        chk("t1_act", 64'(fb_act[0]), 7);
        chk("t1_qcnt0", 64'(qcnt), 0);

        // dual lane match
        set_pred(0, 32'h10, 1, 1); set_pred(1, 32'h14, 2, 0);
        step(); idle();
        set_exe(0, 32'h10, 1); set_exe(1, 32'h14, 3);
        step(); idle();
        chk("t2_fbv", 64'(fb_v), 2'b11);
        chk("t2_mis", 64'(fb_mis), 2'b10);
        chk("t2_conf", 64'(fb_conf), 2'b01);
        chk("t2_sc", 64'(s_c), 1);
        chk("t2_sm", 64'(s_m), 0);
        chk("t2_pc1", 64'(fb_pc[1]), 32'h14);

        // full queue
        for (int k = 0; k < 32; k++) begin
            set_pred(0, 32'h1000 + 32'(8*k), 32'(k), 0);
            set_pred(1, 32'h1004 + 32'(8*k), 32'(k), 0);
            step(); idle();
        end
        chk("t3_full", 64'(qcnt), 64);
        chk("t3_sd0", 64'(s_d), 0);
        set_pred(0, 32'h9000, 0, 0); set_pred(1, 32'h9004, 0, 0);
        step(); idle();
        chk("t3_sd2", 64'(s_d), 2);
        chk("t3_full2", 64'(qcnt), 64);
        set_pred(0, 32'h9100, 0, 0); set_pred(1, 32'h9104, 0, 0);
        set_exe(0, 32'h1000, 0);
        step(); idle();
        chk("t3_sd3", 64'(s_d), 3);
        chk("t3_full3", 64'(qcnt), 64);
        chk("t3_fbv", 64'(fb_v), 1);
        chk("t3_pc", 64'(fb_pc[0]), 32'h1000);
        flush = 1'b1;
        step(); idle();
        chk("t3_drain", 64'(qcnt), 0);
        chk("t3_sd_keep", 64'(s_d), 3);

        // pc mismatch on lane 1 only
        chk("t5_err0", 64'(err), 0);
        set_pred(0, 32'h40, 0, 1);
        step(); idle();
        set_exe(1, 32'h44, 0);
        step(); idle();
        chk("t5_fbv", 64'(fb_v), 0);
        chk("t5_err", 64'(err), 1);
        chk("t5_qcnt", 64'(qcnt), 0);
        chk("t5_sm", 64'(s_m), 0);
        chk("t5_hold", 64'(fb_pc[0]), 32'h1000);

        // flush with traffic
        set_pred(0, 32'h50, 0, 1); set_pred(1, 32'h54, 0, 1);
        step(); idle();
        set_pred(0, 32'h58, 0, 1);
        step(); idle();
        chk("t6_q3", 64'(qcnt), 3);
        set_pred(0, 32'h60, 0, 1); set_pred(1, 32'h64, 0, 1);
        set_exe(0, 32'h50, 0);
        flush = 1'b1;
        step(); idle();
        chk("t6_qcnt", 64'(qcnt), 0);
        chk("t6_fbv", 64'(fb_v), 0);
        chk("t6_sd", 64'(s_d), 5);
        chk("t6_sc", 64'(s_c), 1);
        step();
        chk("t6_fbv2", 64'(fb_v), 0);
        chk("t6_err", 64'(err), 1);

        // streaming across the wrap point
        mc = 1; mm = 0; md = 5; pcb = 32'h4000;
        for (int c = 0; c < 200; c++) begin
            idle();
            idx = 0;
            exv = '0;
            ev_r = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                if (ev_r[p]) begin
                    act_e[p] = 32'($urandom_range(0, 3));
                    if (idx < mq.size()) begin
                        exp_e[p] = mq[idx];
                        set_exe(p, mq[idx].pc, act_e[p]);
                        exv[p] = 1'b1;
                        idx++;
                    end else begin
                        set_exe(p, 32'hdead0000, act_e[p]);
                    end
                end
            end
            repeat (idx) void'(mq.pop_front());
            pv_r = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                if (pv_r[p]) begin
                    ne.pc = pcb;
                    ne.result = 32'($urandom_range(0, 3));
                    ne.conf = 1'($urandom_range(0, 1));
                    pcb = pcb + 32'd4;
                    set_pred(p, ne.pc, ne.result, ne.conf);
                    if (mq.size() < D) mq.push_back(ne);
                    else md++;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (exv[p] && exp_e[p].conf) begin
                    if (exp_e[p].result == act_e[p]) mc++;
                    else mm++;
                end
            end
            step();
            chk("s_fbv", 64'(fb_v), 64'(exv));
            for (int p = 0; p < 2; p++) begin
                if (exv[p]) begin
                    chk("s_pc", 64'(fb_pc[p]), 64'(exp_e[p].pc));
                    chk("s_act", 64'(fb_act[p]), 64'(act_e[p]));
                    chk("s_mis", 64'(fb_mis[p]),
                        64'(exp_e[p].result != act_e[p]));
                    chk("s_conf", 64'(fb_conf[p]), 64'(exp_e[p].conf));
                end
            end
            chk("s_qcnt", 64'(qcnt), 64'(mq.size()));
            chk("s_qmax", 64'(qcnt <= 7'd64), 1);
        end
        idle();
        chk("s_sc", 64'(s_c), 64'(mc));
        chk("s_sm", 64'(s_m), 64'(mm));
        chk("s_sd", 64'(s_d), 64'(md));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vp_validator.md
Name: vp_validator

Overview:
- Consumer end of the value-predictor protocol.
- Captures every prediction the predictor emits on its prediction interface into an in-order in-flight queue.
- Matches queued predictions against program-ordered execution results and drives the predictor's feedback interface (pc, actual, mispredict, conf, valid).
- Keeps saturating accuracy statistics.
- Sits between the predictor and the core's execute/commit stage.

Parameters:
- P_NUM_PRED, 2, lanes per cycle on both interfaces; legal values 1 or 2.
- P_QUEUE_DEPTH, 64, in-flight prediction entries; power of 2, at least 4.
- P_STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk_i  in  1  main clock
- rst_ni  in  1  asynchronous active-low reset
- pred_pc_i  in  P_NUM_PRED x 32  pc of prediction
- pred_result_i  in  P_NUM_PRED x 32  predicted value
- pred_conf_i  in  P_NUM_PRED  prediction confidence saturated
- pred_valid_i  in  P_NUM_PRED  prediction lane qualifier
- exe_pc_i  in  P_NUM_PRED x 32  pc of executed instruction
- exe_actual_i  in  P_NUM_PRED x 32  true result
- exe_valid_i  in  P_NUM_PRED  execution lane qualifier
- flush_i  in  1  squash all in-flight predictions
- fb_pc_o  out  P_NUM_PRED x 32  feedback pc
- fb_actual_o  out  P_NUM_PRED x 32  feedback true result
- fb_mispredict_o  out  P_NUM_PRED  predicted value differs from actual
- fb_conf_o  out  P_NUM_PRED  stored pred_conf of the entry
- fb_valid_o  out  P_NUM_PRED  feedback lane qualifier
- q_count_o  out  clog2(P_QUEUE_DEPTH)+1  current occupancy
- stat_correct_o  out  P_STAT_WIDTH  confident and correct count
- stat_mispred_o  out  P_STAT_WIDTH  confident and wrong count
- stat_drop_o  out  P_STAT_WIDTH  predictions dropped on full queue
- err_pc_mismatch_o  out  1  sticky: exe pc differed from head entry pc

Behaviour:
- Reset (rst_ni low, async): queue empty, all fb_* outputs 0, q_count_o 0, all stats 0, err flag 0.
- Enqueue:
  - Valid pred lanes are compacted in lane order (lane 0 is older) and written at the tail.
  - Entry holds {pc, result, conf}.
- Dequeue:
  - Each valid exe lane, in lane order, consumes the next head entry.
  - exe_valid_i = 2'b10 consumes exactly one entry, matched to lane 1.
- Capacity:
  - Free space is computed after same-cycle dequeue: enqueue accepted if count - deq + enq <= P_QUEUE_DEPTH.
  - Excess valid pred lanes are dropped, higher lane first.
  - stat_drop_o increments by the number of dropped lanes.
- Underflow: an exe lane with no entry available produces no feedback and has no state effect.
- Feedback:
  - Registered; fb lane p valid exactly 1 cycle after the exe lane p that consumed an entry.
  - fb_pc_o = entry pc; fb_actual_o = exe_actual_i.
  - fb_mispredict_o = (entry result != exe_actual_i); fb_conf_o = entry conf.
  - fb outputs hold their last values when fb_valid_o is 0.
- PC mismatch (exe_pc_i != entry pc):
  - Entry is still popped, but no feedback is produced for that lane (fb_valid_o lane 0).
  - err_pc_mismatch_o is set and cleared only by reset.
- Statistics: per fb-valid lane with conf=1, increment stat_correct_o or stat_mispred_o. All counters saturate at all-ones.
- flush_i:
  - Empties the queue that cycle.
  - Suppresses same-cycle enqueue, dequeue and next-cycle fb_valid_o.
  - No stats change, except stat_drop_o, which counts the suppressed enqueue lanes.
- Pointers:
  - clog2(P_QUEUE_DEPTH)+1 bits; full/empty are distinguished by the wrap bit.
  - Two-entry enqueue/dequeue may straddle the wrap point.
- P_NUM_PRED = 1: lane-1 logic absent; behaviour identical on lane 0.

Decomposition:
- Package vp_pkg:
  - pred_entry_t struct {logic [31:0] pc; logic [31:0] result; logic conf;}
  - Counter-saturate function.
  - VP_WORD_WIDTH = 32.
- Sub-module vp_pred_queue:
  - Circular buffer of pred_entry_t, up to 2 writes and 2 reads per cycle.
  - Inputs: enq_cnt, deq_cnt, flush.
  - Outputs: head and head+1 entries, count.
- vp_validator holds the compaction, compare, feedback registers and statistics.

Test Plan:
1. Reset mid-traffic with 5 entries queued → same cycle: q_count_o=0 and fb_valid_o=0, stats 0. After release, pred pc=0x100 result=7 then exe pc=0x100 actual=7 → fb_valid_o=01, fb_mispredict_o=0.
2. Dual pred {pc 0x10 res 1 conf 1, pc 0x14 res 2 conf 0}, then dual exe actual {1,3} → fb_valid_o=11, fb_mispredict_o=10, fb_conf_o=01, stat_correct_o=1, stat_mispred_o=0.
3. Fill queue to 64, then dual pred with no exe → stat_drop_o=2, count stays 64. Fill to 64, then dual pred with single exe → one accepted, one dropped, count 64.
4. Pointer wrap: stream 200 dual preds/exes with random values → fb sequence matches a scoreboard model, count never exceeds 64.
5. exe_valid_i=10 with 1 entry (pc 0x40) and exe_pc 0x44 → entry popped, fb_valid_o=00, err_pc_mismatch_o=1, count 0.
6. flush_i with 3 entries while pred valid=11 and exe valid=01 → count 0 next cycle, fb_valid_o=00, stat_drop_o +2.
